// File: rtl/multi_zone_clock.sv
// -----------------------------------------------------------------------------
// multi_zone_clock
//
// Purpose:
//   N-zone world clock core. A single base UTC time (hh:mm:ss) advances on an
//   internal 1 Hz tick derived from clk. Each zone 1..N_ZONES-1 carries a
//   signed offset in 15-minute quarters (range -48..+56). Zone 0 is UTC and
//   its offset is always 0. Three raw buttons step the displayed zone and
//   edit either the base time (zone 0) or the offset of the displayed zone.
//   The local time of the displayed zone and its day relation to UTC are
//   presented on registered outputs.
//
// Parameters:
//   CLK_HZ   clk frequency in Hz; the prescaler counts 0..CLK_HZ-1
//   N_ZONES  number of zones (>= 2)
//   ZW       zone index width, derived from N_ZONES
//
// Ports:
//   clk         in   1   system clock
//   reset_n     in   1   asynchronous reset, active-low
//   sel_next    in   1   raw button: advance displayed zone
//   hour_inc    in   1   raw button: +1 h (zone 0) / +4 quarters (others)
//   min_inc     in   1   raw button: +1 min (zone 0) / +1 quarter (others)
//   disp_zone   out  ZW  displayed zone index
//   disp_hours  out  5   local hours of the displayed zone
//   disp_mins   out  6   local minutes of the displayed zone
//   disp_secs   out  6   seconds (shared by all zones)
//   zone_day    out  2   local day vs UTC: 00 same, 01 next, 11 previous
//   day_carry   out  1   one-cycle pulse when base wraps 23:59:59 -> 00:00:00
//
// Optional build macro WORLD_CLOCK_AMPM_EN adds:
//   ampm_mode   in   1   1 = 12 h display, 0 = 24 h display
//   disp_pm     out  1   high for local 12:00..23:59 in 12 h mode
// -----------------------------------------------------------------------------
module multi_zone_clock #(
  parameter int CLK_HZ  = 100,
  parameter int N_ZONES = 4,
  localparam int ZW     = (N_ZONES > 2) ? $clog2(N_ZONES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sel_next,
  input  logic          hour_inc,
  input  logic          min_inc,
`ifdef WORLD_CLOCK_AMPM_EN
  input  logic          ampm_mode,
  output logic          disp_pm,
`endif
  output logic [ZW-1:0] disp_zone,
  output logic [4:0]    disp_hours,
  output logic [5:0]    disp_mins,
  output logic [5:0]    disp_secs,
  output logic [1:0]    zone_day,
  output logic          day_carry
);

  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [ZW-1:0] ZONE_MAX  = ZW'(N_ZONES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     presc_q, presc_d;
  logic [5:0]        secs_q, secs_d;
  logic [5:0]        mins_q, mins_d;
  logic [4:0]        hours_q, hours_d;
  logic [ZW-1:0]     zone_q, zone_d;
  logic signed [7:0] off_q [N_ZONES];
  logic signed [7:0] off_d [N_ZONES];
  logic              day_carry_d;

  // Button pipeline, bit order {min_inc, hour_inc, sel_next}
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] btn_edge;
  logic       sel_edge, hour_edge, min_edge;

  // Registered outputs
  logic [ZW-1:0] disp_zone_q;
  logic [4:0]    disp_hours_q, disp_hours_d;
  logic [5:0]    disp_mins_q, disp_mins_d;
  logic [5:0]    disp_secs_q;
  logic [1:0]    zone_day_q, zone_day_d;
  logic          day_carry_q;

  assign btn_edge  = sync2_q & ~prev_q;
  assign sel_edge  = btn_edge[0];
  assign hour_edge = btn_edge[1];
  assign min_edge  = btn_edge[2];

  // ---------------------------------------------------------------------------
  // Next-state logic for time base, zone selection and offsets
  // ---------------------------------------------------------------------------
  logic              sec_tick;
  logic              base_adj;
  logic              off_adj;
  logic signed [7:0] off_cur;
  logic [7:0]        off_step;
  logic signed [7:0] off_sum;

  always_comb begin
    presc_d     = presc_q;
    secs_d      = secs_q;
    mins_d      = mins_q;
    hours_d     = hours_q;
    zone_d      = zone_q;
    off_d       = off_q;
    day_carry_d = 1'b0;
    off_step    = 8'd0;
    off_sum     = 8'sd0;

    sec_tick = (presc_q == PRESC_MAX);
    base_adj = (zone_q == '0) && (hour_edge || min_edge);
    off_adj  = (zone_q != '0) && (hour_edge || min_edge);
    off_cur  = off_q[zone_q];

    presc_d = sec_tick ? '0 : presc_q + 1'b1;

    if (base_adj) begin
      // Editing the base restarts the current second; a coincident tick
      // is discarded so the edit never produces a carry.
      if (hour_edge) hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
      if (min_edge)  mins_d  = (mins_q  == 6'd59) ? 6'd0 : mins_q  + 6'd1;
      secs_d  = 6'd0;
      presc_d = '0;
    end else if (sec_tick) begin
      if (secs_q == 6'd59) begin
        secs_d = 6'd0;
        if (mins_q == 6'd59) begin
          mins_d = 6'd0;
          if (hours_q == 5'd23) begin
            hours_d     = 5'd0;
            day_carry_d = 1'b1;
          end else begin
            hours_d = hours_q + 5'd1;
          end
        end else begin
          mins_d = mins_q + 6'd1;
        end
      end else begin
        secs_d = secs_q + 6'd1;
      end
    end

    // Offset edit uses the zone shown this cycle, even if sel_next also fires.
    // hour adds 4 quarters, min adds 1; both together add 5.
    if (off_adj) begin
      off_step = {5'b0, hour_edge, 1'b0, min_edge};
      off_sum  = off_cur + $signed(off_step);
      // Past +56 the offset wraps to the bottom of the range: 57 -> -48.
      if (off_sum > 8'sd56) off_sum = off_sum - 8'sd105;
      off_d[zone_q] = off_sum;
    end

    if (sel_edge) zone_d = (zone_q == ZONE_MAX) ? '0 : zone_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Local time of the displayed zone
  // ---------------------------------------------------------------------------
  // 13 signed bits: 1439 + 15*56 = 2279 does not fit in 12 signed bits.
  logic [10:0]        base_min;
  logic signed [12:0] off_min;
  logic signed [12:0] local_raw;
  logic signed [12:0] local_adj;
  logic [10:0]        local_u;
  logic [4:0]         loc_hours;
  logic [5:0]         loc_mins;
`ifdef WORLD_CLOCK_AMPM_EN
  logic               disp_pm_q, disp_pm_d;
`endif

  always_comb begin
    base_min  = 11'(hours_q) * 11'd60 + 11'(mins_q);
    off_min   = $signed({{5{off_cur[7]}}, off_cur}) * 13'sd15;
    local_raw = $signed({2'b00, base_min}) + off_min;
    local_adj = local_raw;
    zone_day_d = 2'b00;
    if (local_raw < 13'sd0) begin
      local_adj  = local_raw + 13'sd1440;
      zone_day_d = 2'b11;
    end else if (local_raw >= 13'sd1440) begin
      local_adj  = local_raw - 13'sd1440;
      zone_day_d = 2'b01;
    end
    local_u   = 11'(local_adj);
    loc_hours = 5'(local_u / 11'd60);
    loc_mins  = 6'(local_u % 11'd60);

    disp_hours_d = loc_hours;
    disp_mins_d  = loc_mins;
`ifdef WORLD_CLOCK_AMPM_EN
    disp_pm_d = 1'b0;
    if (ampm_mode) begin
      disp_pm_d = (loc_hours >= 5'd12);
      if (loc_hours == 5'd0)      disp_hours_d = 5'd12;
      else if (loc_hours > 5'd12) disp_hours_d = loc_hours - 5'd12;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      secs_q       <= '0;
      mins_q       <= '0;
      hours_q      <= '0;
      zone_q       <= '0;
      for (int i = 0; i < N_ZONES; i++) off_q[i] <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      disp_zone_q  <= '0;
      disp_hours_q <= '0;
      disp_mins_q  <= '0;
      disp_secs_q  <= '0;
      zone_day_q   <= '0;
      day_carry_q  <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      secs_q       <= secs_d;
      mins_q       <= mins_d;
      hours_q      <= hours_d;
      zone_q       <= zone_d;
      off_q        <= off_d;
      sync1_q      <= {min_inc, hour_inc, sel_next};
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      disp_zone_q  <= zone_q;
      disp_hours_q <= disp_hours_d;
      disp_mins_q  <= disp_mins_d;
      disp_secs_q  <= secs_q;
      zone_day_q   <= zone_day_d;
      day_carry_q  <= day_carry_d;
    end
  end

`ifdef WORLD_CLOCK_AMPM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) disp_pm_q <= 1'b0;
    else          disp_pm_q <= disp_pm_d;
  end
  assign disp_pm = disp_pm_q;
`endif

  assign disp_zone  = disp_zone_q;
  assign disp_hours = disp_hours_q;
  assign disp_mins  = disp_mins_q;
  assign disp_secs  = disp_secs_q;
  assign zone_day   = zone_day_q;
  assign day_carry  = day_carry_q;

endmodule

// File: tb/tb_multi_zone_clock.sv
// -----------------------------------------------------------------------------
// tb_multi_zone_clock
//
// Directed bench for multi_zone_clock (CLK_HZ=100, N_ZONES=4). Inputs are
// driven and outputs sampled on the falling edge of clk. One button press is
// one cycle high followed by three low cycles, which leaves the effect
// visible on the outputs when the press task returns.
// -----------------------------------------------------------------------------
module tb_multi_zone_clock;

  localparam logic [2:0] B_SEL = 3'b001;
  localparam logic [2:0] B_HR  = 3'b010;
  localparam logic [2:0] B_MIN = 3'b100;

  logic       clk;
  logic       reset_n;
  logic       sel_next;
  logic       hour_inc;
  logic       min_inc;
  logic [1:0] disp_zone;
  logic [4:0] disp_hours;
  logic [5:0] disp_mins;
  logic [5:0] disp_secs;
  logic [1:0] zone_day;
  logic       day_carry;
`ifdef WORLD_CLOCK_AMPM_EN
  logic       ampm_mode;
  logic       disp_pm;
`endif

  int checks = 0;
  int passed = 0;

  multi_zone_clock #(
    .CLK_HZ (100),
    .N_ZONES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel_next  (sel_next),
    .hour_inc  (hour_inc),
    .min_inc   (min_inc),
`ifdef WORLD_CLOCK_AMPM_EN
    .ampm_mode (ampm_mode),
    .disp_pm   (disp_pm),
`endif
    .disp_zone (disp_zone),
    .disp_hours(disp_hours),
    .disp_mins (disp_mins),
    .disp_secs (disp_secs),
    .zone_day  (zone_day),
    .day_carry (day_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    sel_next = 1'b0;
    hour_inc = 1'b0;
    min_inc  = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic press(input logic [2:0] b);
    sel_next = b[0];
    hour_inc = b[1];
    min_inc  = b[2];
    step(1);
    sel_next = 1'b0;
    hour_inc = 1'b0;
    min_inc  = 1'b0;
    step(3);
  endtask

  task automatic press_n(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic test_reset();
    do_reset();
    press(B_HR);
    press(B_SEL);
    reset_n = 1'b0;
    #1;
    checks++; if (disp_zone  !== 2'd0) $display("FAIL reset_zone: got %0d want 0", disp_zone);  else passed++;
    checks++; if (disp_hours !== 5'd0) $display("FAIL reset_hours: got %0d want 0", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd0) $display("FAIL reset_mins: got %0d want 0", disp_mins);   else passed++;
    checks++; if (disp_secs  !== 6'd0) $display("FAIL reset_secs: got %0d want 0", disp_secs);   else passed++;
    checks++; if (zone_day   !== 2'd0) $display("FAIL reset_day: got %0d want 0", zone_day);     else passed++;
    checks++; if (day_carry  !== 1'b0) $display("FAIL reset_carry: got %0d want 0", day_carry);  else passed++;
    $display("test_reset: outputs %0d %0d:%0d:%0d day=%0d", disp_zone, disp_hours, disp_mins, disp_secs, zone_day);
    step(1);
    reset_n = 1'b1;
  endtask

  task automatic test_prescaler();
    do_reset();
    step(100);
    checks++; if (disp_secs !== 6'd0) $display("FAIL presc_edge100_secs: got %0d want 0", disp_secs); else passed++;
    step(1);
    checks++; if (disp_secs !== 6'd1) $display("FAIL presc_edge101_secs: got %0d want 1", disp_secs); else passed++;
    step(5899);
    checks++; if (disp_mins !== 6'd0)  $display("FAIL presc_59s_mins: got %0d want 0", disp_mins);  else passed++;
    checks++; if (disp_secs !== 6'd59) $display("FAIL presc_59s_secs: got %0d want 59", disp_secs); else passed++;
    step(1);
    checks++; if (disp_mins !== 6'd1) $display("FAIL presc_60s_mins: got %0d want 1", disp_mins); else passed++;
    checks++; if (disp_secs !== 6'd0) $display("FAIL presc_60s_secs: got %0d want 0", disp_secs); else passed++;
    $display("test_prescaler: time %0d:%0d:%0d", disp_hours, disp_mins, disp_secs);
  endtask

  task automatic test_day_carry();
    int pulses;
    pulses = 0;
    do_reset();
    press_n(B_HR, 23);
    press_n(B_MIN, 59);
    checks++; if (disp_hours !== 5'd23) $display("FAIL dc_set_hours: got %0d want 23", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd59) $display("FAIL dc_set_mins: got %0d want 59", disp_mins);   else passed++;
    checks++; if (disp_secs  !== 6'd0)  $display("FAIL dc_set_secs: got %0d want 0", disp_secs);    else passed++;
    for (int i = 0; i < 5998; i++) begin
      step(1);
      if (day_carry === 1'b1) pulses++;
    end
    checks++; if (disp_secs !== 6'd59) $display("FAIL dc_pre_secs: got %0d want 59", disp_secs); else passed++;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (day_carry === 1'b1) pulses++;
    end
    checks++; if (pulses     !== 1)     $display("FAIL dc_pulse_count: got %0d want 1", pulses);    else passed++;
    checks++; if (disp_hours !== 5'd0)  $display("FAIL dc_wrap_hours: got %0d want 0", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd0)  $display("FAIL dc_wrap_mins: got %0d want 0", disp_mins);   else passed++;
    checks++; if (disp_secs  !== 6'd0)  $display("FAIL dc_wrap_secs: got %0d want 0", disp_secs);   else passed++;
    checks++; if (zone_day   !== 2'b00) $display("FAIL dc_wrap_day: got %0d want 0", zone_day);     else passed++;
    $display("test_day_carry: pulses=%0d time %0d:%0d:%0d", pulses, disp_hours, disp_mins, disp_secs);
  endtask

  task automatic test_next_day();
    do_reset();
    press_n(B_HR, 22);
    checks++; if (disp_hours !== 5'd22) $display("FAIL nd_base_hours: got %0d want 22", disp_hours); else passed++;
    press(B_SEL);
    press_n(B_HR, 5);
    checks++; if (disp_zone  !== 2'd1)  $display("FAIL nd_zone: got %0d want 1", disp_zone);    else passed++;
    checks++; if (disp_hours !== 5'd3)  $display("FAIL nd_hours: got %0d want 3", disp_hours);  else passed++;
    checks++; if (disp_mins  !== 6'd0)  $display("FAIL nd_mins: got %0d want 0", disp_mins);    else passed++;
    checks++; if (zone_day   !== 2'b01) $display("FAIL nd_day: got %0d want 1", zone_day);      else passed++;
    $display("test_next_day: zone %0d %0d:%0d day=%0d", disp_zone, disp_hours, disp_mins, zone_day);
  endtask

  task automatic test_offset_wrap();
    do_reset();
    press_n(B_HR, 5);
    press_n(B_SEL, 2);
    press_n(B_MIN, 56);
    checks++; if (disp_zone  !== 2'd2)  $display("FAIL ow_zone: got %0d want 2", disp_zone);         else passed++;
    checks++; if (disp_hours !== 5'd19) $display("FAIL ow_max_hours: got %0d want 19", disp_hours);  else passed++;
    checks++; if (zone_day   !== 2'b00) $display("FAIL ow_max_day: got %0d want 0", zone_day);       else passed++;
    press(B_MIN);
    checks++; if (disp_hours !== 5'd17) $display("FAIL ow_wrap_hours: got %0d want 17", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd0)  $display("FAIL ow_wrap_mins: got %0d want 0", disp_mins);    else passed++;
    checks++; if (zone_day   !== 2'b11) $display("FAIL ow_wrap_day: got %0d want 3", zone_day);      else passed++;
    $display("test_offset_wrap: zone %0d %0d:%0d day=%0d", disp_zone, disp_hours, disp_mins, zone_day);
  endtask

  task automatic test_sel_hold();
    do_reset();
    sel_next = 1'b1;
    step(50);
    sel_next = 1'b0;
    step(4);
    checks++; if (disp_zone !== 2'd1) $display("FAIL sel_hold_zone: got %0d want 1", disp_zone); else passed++;
    press_n(B_SEL, 2);
    checks++; if (disp_zone !== 2'd3) $display("FAIL sel_three_zone: got %0d want 3", disp_zone); else passed++;
    press(B_SEL);
    checks++; if (disp_zone !== 2'd0) $display("FAIL sel_wrap_zone: got %0d want 0", disp_zone); else passed++;
    $display("test_sel_hold: zone %0d", disp_zone);
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(B_SEL);
    press(B_SEL | B_MIN);
    checks++; if (disp_zone !== 2'd2) $display("FAIL sim_sel_zone: got %0d want 2", disp_zone); else passed++;
    checks++; if (disp_mins !== 6'd0) $display("FAIL sim_new_zone_mins: got %0d want 0", disp_mins); else passed++;
    press_n(B_SEL, 3);
    checks++; if (disp_zone !== 2'd1)  $display("FAIL sim_back_zone: got %0d want 1", disp_zone);  else passed++;
    checks++; if (disp_mins !== 6'd15) $display("FAIL sim_old_zone_mins: got %0d want 15", disp_mins); else passed++;
    press(B_HR | B_MIN);
    checks++; if (disp_hours !== 5'd1)  $display("FAIL sim_both_off_hours: got %0d want 1", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd30) $display("FAIL sim_both_off_mins: got %0d want 30", disp_mins);  else passed++;
    press_n(B_SEL, 3);
    press(B_HR | B_MIN);
    checks++; if (disp_zone  !== 2'd0) $display("FAIL sim_base_zone: got %0d want 0", disp_zone);   else passed++;
    checks++; if (disp_hours !== 5'd1) $display("FAIL sim_base_hours: got %0d want 1", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd1) $display("FAIL sim_base_mins: got %0d want 1", disp_mins);   else passed++;
    checks++; if (disp_secs  !== 6'd0) $display("FAIL sim_base_secs: got %0d want 0", disp_secs);   else passed++;
    $display("test_simultaneous: zone %0d %0d:%0d:%0d", disp_zone, disp_hours, disp_mins, disp_secs);
  endtask

  task automatic test_async_reset();
    do_reset();
    press(B_SEL);
    press(B_HR);
    press_n(B_SEL, 3);
    press_n(B_HR, 12);
    press_n(B_MIN, 34);
    step(5600);
    checks++; if (disp_hours !== 5'd12) $display("FAIL ar_pre_hours: got %0d want 12", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd34) $display("FAIL ar_pre_mins: got %0d want 34", disp_mins);   else passed++;
    checks++; if (disp_secs  !== 6'd56) $display("FAIL ar_pre_secs: got %0d want 56", disp_secs);   else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (disp_hours !== 5'd0) $display("FAIL ar_hours: got %0d want 0", disp_hours); else passed++;
    checks++; if (disp_mins  !== 6'd0) $display("FAIL ar_mins: got %0d want 0", disp_mins);   else passed++;
    checks++; if (disp_secs  !== 6'd0) $display("FAIL ar_secs: got %0d want 0", disp_secs);   else passed++;
    step(1);
    reset_n = 1'b1;
    press(B_SEL);
    checks++; if (disp_zone  !== 2'd1) $display("FAIL ar_post_zone: got %0d want 1", disp_zone);   else passed++;
    checks++; if (disp_hours !== 5'd0) $display("FAIL ar_post_offset_hours: got %0d want 0", disp_hours); else passed++;
    $display("test_async_reset: zone %0d %0d:%0d", disp_zone, disp_hours, disp_mins);
  endtask

`ifdef WORLD_CLOCK_AMPM_EN
  task automatic test_ampm();
    do_reset();
    ampm_mode = 1'b1;
    press_n(B_HR, 13);
    press_n(B_MIN, 5);
    checks++; if (disp_hours !== 5'd1) $display("FAIL ampm_13_hours: got %0d want 1", disp_hours); else passed++;
    checks++; if (disp_pm    !== 1'b1) $display("FAIL ampm_13_pm: got %0d want 1", disp_pm);       else passed++;
    ampm_mode = 1'b0;
    step(2);
    checks++; if (disp_hours !== 5'd13) $display("FAIL ampm_24h_hours: got %0d want 13", disp_hours); else passed++;
    checks++; if (disp_pm    !== 1'b0)  $display("FAIL ampm_24h_pm: got %0d want 0", disp_pm);        else passed++;
    do_reset();
    ampm_mode = 1'b1;
    press_n(B_MIN, 10);
    checks++; if (disp_hours !== 5'd12) $display("FAIL ampm_00_hours: got %0d want 12", disp_hours); else passed++;
    checks++; if (disp_pm    !== 1'b0)  $display("FAIL ampm_00_pm: got %0d want 0", disp_pm);        else passed++;
    ampm_mode = 1'b0;
    $display("test_ampm: hours %0d pm=%0d", disp_hours, disp_pm);
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    sel_next = 1'b0;
    hour_inc = 1'b0;
    min_inc  = 1'b0;
`ifdef WORLD_CLOCK_AMPM_EN
    ampm_mode = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_prescaler();
    test_day_carry();
    test_next_day();
    test_offset_wrap();
    test_sel_hold();
    test_simultaneous();
    test_async_reset();
`ifdef WORLD_CLOCK_AMPM_EN
    test_ampm();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
